// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer and its helpers.
// Holds the sequencer state encoding and the power-on cause code.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_SRC_CLR = 3'd0,
      ST_WAIT_STABLE  = 3'd1,
      ST_HOLD         = 3'd2,
      ST_STAGGER      = 3'd3,
      ST_RUN          = 3'd4
   } seq_state_e;

   localparam int CAUSE_POR = 0;

endpackage

// File: rtl/reset_stretch.sv
// Local reset request stretcher for one domain: the hold output stays high
// while the request is high and for LOCAL_EXT cycles after it falls.
module reset_stretch #(
   parameter int LOCAL_EXT = 4
) (
   input  logic clk_gp_100mhz,
   input  logic rst,
   input  logic en,
   input  logic req,
   output logic hold
);

   localparam int EXT_W = (LOCAL_EXT > 0) ? $clog2(LOCAL_EXT + 1) : 1;

   logic [EXT_W-1:0] cnt_q, cnt_d;

   // NOTE: assign every always_comb output a default first so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = '0;
      end else if (req) begin
         cnt_d = EXT_W'(LOCAL_EXT);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_gp_100mhz or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hold = en & (req | (cnt_q != '0));

endmodule

// File: rtl/reset_sequencer_n.sv
// Global reset sequencer: waits for sources to clear and clocks to settle,
// then releases domains one by one; records cause, history and entry count.
module reset_sequencer_n
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS = 6,
   parameter int NUM_SOURCES = 8,
   parameter int HOLD_W      = 8,
   parameter int CNT_W       = 16,
   parameter int LOCAL_EXT   = 4,
   localparam int CAUSE_W    = $clog2(NUM_SOURCES + 1)
) (
   input  logic                   clk_gp_100mhz,
   input  logic                   rst,
   input  logic [NUM_SOURCES-1:0] reset_src_req,
   input  logic [NUM_SOURCES-1:0] src_mask,
   input  logic                   stable_in,
   input  logic [HOLD_W-1:0]      hold_cycles,
   input  logic [HOLD_W-1:0]      stagger_cycles,
   input  logic                   quick_mode,
   input  logic [NUM_DOMAINS-1:0] domain_reset_req,
   input  logic                   history_clr,
   output logic [NUM_DOMAINS-1:0] domain_rst_n,
   output logic                   seq_done,
   output logic [CAUSE_W-1:0]     reset_cause,
   output logic [NUM_SOURCES-1:0] cause_history,
   output logic [CNT_W-1:0]       reset_count,
   output logic [2:0]             seq_state
);

   localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   seq_state_e             state_q, state_d;
   logic [HOLD_W-1:0]      timer_q, timer_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] rel_q, rel_d;
   logic [NUM_DOMAINS-1:0] domain_rst_n_q, domain_rst_n_d;
   logic                   seq_done_q, seq_done_d;
   logic [CAUSE_W-1:0]     cause_q, cause_d;
   logic [NUM_SOURCES-1:0] hist_q, hist_d;
   logic [CNT_W-1:0]       count_q, count_d;

   logic [NUM_SOURCES-1:0] active;
   logic [CAUSE_W-1:0]     first_src;
   logic [NUM_DOMAINS-1:0] local_hold;
   logic                   in_run;

   function automatic logic [HOLD_W-1:0] load_val(input logic [HOLD_W-1:0] cycles,
                                                  input logic quick);
      if (quick || cycles == '0) return HOLD_W'(1);
      return cycles;
   endfunction

   assign active = reset_src_req & ~src_mask;
   assign in_run = (state_q == ST_RUN);

   // Descending scan so the lowest active index is the one left standing.
   always_comb begin
      first_src = CAUSE_W'(CAUSE_POR);
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (active[i]) first_src = CAUSE_W'(i + 1);
      end
   end

   for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_stretch
      reset_stretch #(
         .LOCAL_EXT (LOCAL_EXT)
      ) u_stretch (
         .clk_gp_100mhz (clk_gp_100mhz),
         .rst           (rst),
         .en            (in_run),
         .req           (domain_reset_req[d]),
         .hold          (local_hold[d])
      );
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      rel_d   = rel_q;
      cause_d = cause_q;
      count_d = count_q;
      hist_d  = (history_clr ? '0 : hist_q) | active;

      if (active != '0) begin
         // Only a request seen in RUN is a new reset event; later ones keep the first cause.
         if (state_q == ST_RUN) begin
            cause_d = first_src;
            if (count_q != '1) count_d = count_q + 1'b1;
         end
         rel_d   = '0;
         state_d = ST_WAIT_SRC_CLR;
      end else begin
         unique case (state_q)
            ST_WAIT_SRC_CLR: state_d = ST_WAIT_STABLE;
            ST_WAIT_STABLE: begin
               if (stable_in) begin
                  timer_d = load_val(hold_cycles, quick_mode);
                  state_d = ST_HOLD;
               end
            end
            ST_HOLD, ST_STAGGER: begin
               if (!stable_in) begin
                  rel_d   = '0;
                  state_d = ST_WAIT_STABLE;
               end else if (timer_q > HOLD_W'(1)) begin
                  timer_d = timer_q - 1'b1;
               end else if (state_q == ST_HOLD) begin
                  rel_d = NUM_DOMAINS'(1);
                  if (NUM_DOMAINS == 1) begin
                     state_d = ST_RUN;
                  end else begin
                     idx_d   = IDX_W'(1);
                     timer_d = load_val(stagger_cycles, quick_mode);
                     state_d = ST_STAGGER;
                  end
               end else begin
                  rel_d = rel_q | (NUM_DOMAINS'(1) << idx_q);
                  if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                     state_d = ST_RUN;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     timer_d = load_val(stagger_cycles, quick_mode);
                  end
               end
            end
            ST_RUN: state_d = ST_RUN;
            default: begin
               rel_d   = '0;
               state_d = ST_WAIT_SRC_CLR;
            end
         endcase
      end

      domain_rst_n_d = rel_d & ~local_hold;
      seq_done_d     = (state_d == ST_RUN);
   end

   always_ff @(posedge clk_gp_100mhz or posedge rst) begin
      if (rst) begin
         state_q        <= ST_WAIT_SRC_CLR;
         timer_q        <= '0;
         idx_q          <= '0;
         rel_q          <= '0;
         domain_rst_n_q <= '0;
         seq_done_q     <= 1'b0;
         cause_q        <= CAUSE_W'(CAUSE_POR);
         hist_q         <= '0;
         count_q        <= '0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         idx_q          <= idx_d;
         rel_q          <= rel_d;
         domain_rst_n_q <= domain_rst_n_d;
         seq_done_q     <= seq_done_d;
         cause_q        <= cause_d;
         hist_q         <= hist_d;
         count_q        <= count_d;
      end
   end

   assign domain_rst_n  = domain_rst_n_q;
   assign seq_done      = seq_done_q;
   assign reset_cause   = cause_q;
   assign cause_history = hist_q;
   assign reset_count   = count_q;
   assign seq_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer_n.sv
// Bench for reset_sequencer_n: timestamp-based reference model feeding a
// scoreboard queue, plus directed POR, priority, mask, clock-loss, saturation and local-reset cases.
module tb_reset_sequencer_n;

   localparam int ND  = 4;
   localparam int NS  = 8;
   localparam int HW  = 8;
   localparam int CW  = 4;
   localparam int LE  = 4;
   localparam int CAW = $clog2(NS + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic [NS-1:0] src, mask;
   logic          stable, quick, hist_clr;
   logic [HW-1:0] hold, stagger;
   logic [ND-1:0] dreq;
   logic [ND-1:0] dom;
   logic          seq_done;
   logic [CAW-1:0] cause;
   logic [NS-1:0] hist;
   logic [CW-1:0] cnt;
   logic [2:0]    st;

   always #5 clk = ~clk;

   reset_sequencer_n #(
      .NUM_DOMAINS (ND),
      .NUM_SOURCES (NS),
      .HOLD_W      (HW),
      .CNT_W       (CW),
      .LOCAL_EXT   (LE)
   ) dut (
      .clk_gp_100mhz    (clk),
      .rst              (rst),
      .reset_src_req    (src),
      .src_mask         (mask),
      .stable_in        (stable),
      .hold_cycles      (hold),
      .stagger_cycles   (stagger),
      .quick_mode       (quick),
      .domain_reset_req (dreq),
      .history_clr      (hist_clr),
      .domain_rst_n     (dom),
      .seq_done         (seq_done),
      .reset_cause      (cause),
      .cause_history    (hist),
      .reset_count      (cnt),
      .seq_state        (st)
   );

   typedef struct packed {
      logic [ND-1:0]  dom;
      logic           done;
      logic [CAW-1:0] cause;
      logic [NS-1:0]  hist;
      logic [CW-1:0]  cnt;
   } obs_t;

   obs_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: phases with timestamps instead of timers and indices.
   typedef enum {P_BLOCK, P_WSTAB, P_SEQ, P_RUN} phase_e;
   phase_e  ph;
   longint  edge_n;
   longint  t0;
   int      heff, seff;
   longint  last_req[ND];
   int      m_cause, m_cnt;
   logic [NS-1:0] m_hist;

   function automatic int lowest(input logic [NS-1:0] v);
      for (int i = 0; i < NS; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int eff(input logic [HW-1:0] v, input logic q);
      if (q) return 1;
      return (v == 0) ? 1 : int'(v);
   endfunction

   task automatic model_reset();
      ph = P_BLOCK; edge_n = 0; t0 = 0; heff = 1; seff = 1;
      m_cause = 0; m_cnt = 0; m_hist = '0;
      for (int d = 0; d < ND; d++) last_req[d] = -100;
   endtask

   task automatic model_step();
      logic [NS-1:0] act;
      logic          was_run;
      obs_t          e;
      edge_n++;
      act     = src & ~mask;
      was_run = (ph == P_RUN);
      m_hist  = (hist_clr ? '0 : m_hist) | act;
      if (act != 0) begin
         if (ph == P_RUN) begin
            m_cause = lowest(act) + 1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
         end
         ph = P_BLOCK;
      end else begin
         case (ph)
            P_BLOCK: ph = P_WSTAB;
            P_WSTAB: if (stable) begin
               t0 = edge_n; heff = eff(hold, quick); seff = eff(stagger, quick); ph = P_SEQ;
            end
            P_SEQ: begin
               if (!stable) ph = P_WSTAB;
               else if (edge_n - t0 == longint'(heff + seff * (ND - 1))) ph = P_RUN;
            end
            default: ;
         endcase
      end
      for (int d = 0; d < ND; d++) begin
         if (!was_run) last_req[d] = -100;
         else if (dreq[d]) last_req[d] = edge_n;
      end
      for (int d = 0; d < ND; d++) begin
         case (ph)
            P_RUN:   e.dom[d] = !(was_run && (edge_n - last_req[d] <= LE));
            P_SEQ:   e.dom[d] = (edge_n - t0 >= longint'(heff + seff * d));
            default: e.dom[d] = 1'b0;
         endcase
      end
      e.done  = (ph == P_RUN);
      e.cause = CAW'(m_cause);
      e.hist  = m_hist;
      e.cnt   = CW'(m_cnt);
      exp_q.push_back(e);
   endtask

   // One clock: model consumes the inputs the DUT samples on this edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wait_run(input string name, input int budget);
      int n = 0;
      while (seq_done !== 1'b1 && n < budget) begin
         cycle();
         n++;
      end
      check(name, 64'(seq_done), 64'd1);
   endtask

   // Monitor: every cycle the DUT presents a fresh output word.
   initial begin
      obs_t e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{dom: dom, done: seq_done, cause: cause, hist: hist, cnt: cnt};
            check("scoreboard", 64'(a), 64'(e));
         end
      end
   end

   initial begin
      int rise[ND];
      int done_rise;
      logic [ND-1:0] prev;
      int low_cnt;
      logic others_ok, done_ok, mask_ok;
      int n;

      rst = 1'b1; src = 8'hff; mask = '0; stable = 1'b1; quick = 1'b0;
      hist_clr = 1'b0; hold = 8'd8; stagger = 8'd3; dreq = '0;
      model_reset();

      // Power-on reset
      repeat (5) @(posedge clk);
      #1;
      check("rst_dom", 64'(dom), 64'd0);
      check("rst_done", 64'(seq_done), 64'd0);
      check("rst_cause", 64'(cause), 64'd0);
      check("rst_hist", 64'(hist), 64'd0);
      check("rst_count", 64'(cnt), 64'd0);
      check("rst_state", 64'(st), 64'd0);
      src = '0;
      rst = 1'b0;
      for (int d = 0; d < ND; d++) rise[d] = -1;
      done_rise = -1;
      prev = '0;
      for (int i = 1; i <= 30; i++) begin
         cycle();
         for (int d = 0; d < ND; d++) if (dom[d] && !prev[d] && rise[d] < 0) rise[d] = i;
         if (seq_done && done_rise < 0) done_rise = i;
         prev = dom;
      end
      check("por_dom0_edge", 64'(rise[0]), 64'd10);
      for (int d = 1; d < ND; d++) check("por_stagger", 64'(rise[d] - rise[0]), 64'(3 * d));
      check("por_done_edge", 64'(done_rise), 64'(rise[ND-1]));
      check("por_cause", 64'(cause), 64'd0);
      check("por_count", 64'(cnt), 64'd0);

      // Two sources at once: lowest index wins
      src = 8'b0010_0100;
      cycle();
      src = '0;
      check("prio_dom", 64'(dom), 64'd0);
      check("prio_cause", 64'(cause), 64'd3);
      check("prio_hist", 64'(hist), 64'h24);
      check("prio_count", 64'(cnt), 64'd1);
      wait_run("prio_rerun", 40);

      // Masked source is ignored
      mask = 8'b0000_0010;
      src  = 8'b0000_0010;
      mask_ok = 1'b1;
      repeat (4) begin
         cycle();
         if (dom !== 4'hf) mask_ok = 1'b0;
      end
      check("mask_dom_high", 64'(mask_ok), 64'd1);
      check("mask_count", 64'(cnt), 64'd1);
      check("mask_hist", 64'(hist), 64'h24);
      src = '0;
      cycle();
      mask = '0;

      // Clock loss after domain 1 release
      src = 8'h40;
      cycle();
      src = '0;
      check("loss_cause", 64'(cause), 64'd7);
      n = 0;
      while (dom[1] !== 1'b1 && n < 40) begin
         cycle();
         n++;
      end
      check("loss_dom1_up", 64'(dom[1]), 64'd1);
      stable = 1'b0;
      cycle();
      check("loss_dom", 64'(dom), 64'd0);
      check("loss_state", 64'(st), 64'd1);
      stable = 1'b1;
      wait_run("loss_rerun", 40);
      check("loss_cause_kept", 64'(cause), 64'd7);
      check("loss_count_kept", 64'(cnt), 64'd2);

      // Local domain reset stretch
      cycle();
      low_cnt = 0; others_ok = 1'b1; done_ok = 1'b1;
      dreq = 4'b0100;
      for (int i = 0; i < 15; i++) begin
         cycle();
         if (i == 2) dreq = '0;
         if (!dom[2]) low_cnt++;
         if ({dom[3], dom[1:0]} !== 3'b111) others_ok = 1'b0;
         if (seq_done !== 1'b1) done_ok = 1'b0;
      end
      check("local_low_cycles", 64'(low_cnt), 64'd7);
      check("local_others", 64'(others_ok), 64'd1);
      check("local_done", 64'(done_ok), 64'd1);

      // Counter saturation
      quick = 1'b1;
      for (int p = 0; p < 17; p++) begin
         src = 8'h01;
         cycle();
         src = '0;
         wait_run("sat_rerun", 40);
      end
      check("sat_count", 64'(cnt), 64'd15);
      check("sat_cause", 64'(cause), 64'd1);
      quick = 1'b0;

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         cycle();
         if (src != 0) src = ($urandom_range(0, 2) == 0) ? '0 : src;
         else if ($urandom_range(0, 24) == 0) src = NS'($urandom);
         if ($urandom_range(0, 40) == 0) mask = NS'($urandom) & NS'($urandom);
         if ($urandom_range(0, 9) == 0) dreq[$urandom_range(0, ND - 1)] ^= 1'b1;
         hist_clr = ($urandom_range(0, 15) == 0);
         if (stable) stable = ($urandom_range(0, 59) != 0);
         else        stable = ($urandom_range(0, 2) == 0);
         if (ph != P_SEQ && $urandom_range(0, 9) == 0) begin
            hold    = HW'($urandom_range(0, 5));
            stagger = HW'($urandom_range(0, 4));
            quick   = ($urandom_range(0, 3) == 0);
         end
      end

      @(negedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
